// File: rtl/conv2d_mac_array_if.sv
// Operand/result bus of the convolution MAC array: one valid/ready channel in, one out.
// Both channels transfer on a rising edge where valid && ready; valid never waits on ready.
interface conv2d_mac_array_if #(
    parameter int PIXEL_W  = 8,
    parameter int WEIGHT_W = 8,
    parameter int BIAS_W   = 16,
    parameter int OUT_W    = 16,
    parameter int ELEMS    = 27
);
    logic                        in_valid;
    logic                        in_ready;
    logic [ELEMS*PIXEL_W-1:0]    window;
    logic [ELEMS*WEIGHT_W-1:0]   weights;
    logic [BIAS_W-1:0]           bias;
    logic                        relu_en;
    logic                        out_valid;
    logic                        out_ready;
    logic [OUT_W-1:0]            out_px;
    logic                        out_sat;

    modport master (
        output in_valid, window, weights, bias, relu_en, out_ready,
        input  in_ready, out_valid, out_px, out_sat
    );

    modport slave (
        input  in_valid, window, weights, bias, relu_en, out_ready,
        output in_ready, out_valid, out_px, out_sat
    );
endinterface

// File: rtl/conv2d_mac_array.sv
// Multi-channel 2D convolution dot product: LANES signed MACs per cycle over a latched window,
// then round/shift, optional ReLU and saturation to OUT_W.
module conv2d_mac_array #(
    parameter int PIXEL_W      = 8,
    parameter int WEIGHT_W     = 8,
    parameter int BIAS_W       = 16,
    parameter int ACC_W        = 32,
    parameter int OUT_W        = 16,
    parameter int CHANNELS     = 3,
    parameter int WINDOW_ELEMS = 9,
    parameter int LANES        = 3,
    parameter int SHIFT        = 0
) (
    input  logic               clk,
    input  logic               rst,
    conv2d_mac_array_if.slave  bus,
    output logic [1:0]         dbg_state_o
);
    localparam int ELEMS  = CHANNELS * WINDOW_ELEMS;
    localparam int BEATS  = (LANES > 0) ? ELEMS / LANES : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_W-1:0] ROUND   = (SHIFT > 0) ? (ACC_W'(1) << RND_SH) : '0;
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = -OUT_MAX - 1;

    if (LANES < 1 || (ELEMS % ((LANES > 0) ? LANES : 1)) != 0) begin : g_bad_lanes
        $error("conv2d_mac_array: LANES must be >= 1 and divide CHANNELS*WINDOW_ELEMS");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

    state_t                         state_q, state_d;
    logic [BEAT_W-1:0]              beat_q, beat_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic [ELEMS*PIXEL_W-1:0]       win_q, win_d;
    logic [ELEMS*WEIGHT_W-1:0]      wts_q, wts_d;
    logic                           relu_q, relu_d;
    logic [OUT_W-1:0]               out_px_q, out_px_d;
    logic                           out_sat_q, out_sat_d;
    logic signed [ACC_W-1:0]        lane_sum;
    logic signed [ACC_W-1:0]        acc_next;
    logic [OUT_W:0]                 post_res;

    function automatic logic signed [ACC_W-1:0] tap_prod(input int idx);
        logic signed [PIXEL_W-1:0]          p;
        logic signed [WEIGHT_W-1:0]         w;
        logic signed [PIXEL_W+WEIGHT_W-1:0] pr;
        p  = win_q[idx*PIXEL_W +: PIXEL_W];
        w  = wts_q[idx*WEIGHT_W +: WEIGHT_W];
        pr = p * w;
        return ACC_W'(pr);
    endfunction

    // Returns {sat, px}: round-shift first, then ReLU, then clip to the signed OUT_W range.
    function automatic logic [OUT_W:0] post_proc(input logic signed [ACC_W-1:0] a,
                                                 input logic relu);
        logic signed [ACC_W-1:0] v;
        v = a;
        if (SHIFT > 0) v = (v + ROUND) >>> SHIFT;
        if (relu && v < 0) v = '0;
        if (v > OUT_MAX) return {1'b1, OUT_MAX[OUT_W-1:0]};
        if (v < OUT_MIN) return {1'b1, OUT_MIN[OUT_W-1:0]};
        return {1'b0, v[OUT_W-1:0]};
    endfunction

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum + tap_prod(int'(beat_q) * LANES + l);
        end
        acc_next = acc_q + lane_sum;
        post_res = post_proc(acc_next, relu_q);
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        acc_d     = acc_q;
        win_d     = win_q;
        wts_d     = wts_q;
        relu_d    = relu_q;
        out_px_d  = out_px_q;
        out_sat_d = out_sat_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    win_d   = bus.window;
                    wts_d   = bus.weights;
                    relu_d  = bus.relu_en;
                    acc_d   = ACC_W'($signed(bus.bias));
                    beat_d  = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_next;
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    out_px_d  = post_res[OUT_W-1:0];
                    out_sat_d = post_res[OUT_W];
                    state_d   = OUT;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            OUT: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            acc_q     <= '0;
            out_px_q  <= '0;
            out_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            acc_q     <= acc_d;
            out_px_q  <= out_px_d;
            out_sat_q <= out_sat_d;
        end
    end

    // Operand holding registers only change on an accepted handshake, so they need no reset.
    always_ff @(posedge clk) begin
        win_q  <= win_d;
        wts_q  <= wts_d;
        relu_q <= relu_d;
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_px    = out_px_q;
    assign bus.out_sat   = out_sat_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_conv2d_mac_array.sv
// Scoreboard bench for conv2d_mac_array: default instance under directed/random traffic,
// plus SHIFT=2, LANES=1 and LANES=9 instances for latency and rounding.
module tb_conv2d_mac_array;
  localparam int PW = 8;
  localparam int WW = 8;
  localparam int BW = 16;
  localparam int OW = 16;
  localparam int ELEMS = 27;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  conv2d_mac_array_if #(.PIXEL_W(PW), .WEIGHT_W(WW), .BIAS_W(BW), .OUT_W(OW), .ELEMS(ELEMS)) m_if ();
  conv2d_mac_array_if #(.PIXEL_W(PW), .WEIGHT_W(WW), .BIAS_W(BW), .OUT_W(OW), .ELEMS(ELEMS)) sh_if ();
  conv2d_mac_array_if #(.PIXEL_W(PW), .WEIGHT_W(WW), .BIAS_W(BW), .OUT_W(OW), .ELEMS(ELEMS)) l1_if ();
  conv2d_mac_array_if #(.PIXEL_W(PW), .WEIGHT_W(WW), .BIAS_W(BW), .OUT_W(OW), .ELEMS(ELEMS)) l9_if ();

  logic [1:0] m_state, sh_state, l1_state, l9_state;

  conv2d_mac_array u_dut (.clk(clk), .rst(rst), .bus(m_if), .dbg_state_o(m_state));
  conv2d_mac_array #(.SHIFT(2)) u_sh (.clk(clk), .rst(rst), .bus(sh_if), .dbg_state_o(sh_state));
  conv2d_mac_array #(.LANES(1)) u_l1 (.clk(clk), .rst(rst), .bus(l1_if), .dbg_state_o(l1_state));
  conv2d_mac_array #(.LANES(9)) u_l9 (.clk(clk), .rst(rst), .bus(l9_if), .dbg_state_o(l9_state));

  // ---------------- variant instances: shared operands, per-instance valid
  logic                 v_valid[3];
  logic [ELEMS*PW-1:0]  v_win;
  logic [ELEMS*WW-1:0]  v_wts;
  logic [BW-1:0]        v_bias;
  logic                 v_in_ready[3];
  logic                 v_out_valid[3];
  logic [OW-1:0]        v_out_px[3];
  logic                 v_out_sat[3];

  assign sh_if.in_valid = v_valid[0];
  assign l1_if.in_valid = v_valid[1];
  assign l9_if.in_valid = v_valid[2];
  assign sh_if.window = v_win;   assign l1_if.window = v_win;   assign l9_if.window = v_win;
  assign sh_if.weights = v_wts;  assign l1_if.weights = v_wts;  assign l9_if.weights = v_wts;
  assign sh_if.bias = v_bias;    assign l1_if.bias = v_bias;    assign l9_if.bias = v_bias;
  assign sh_if.relu_en = 1'b0;   assign l1_if.relu_en = 1'b0;   assign l9_if.relu_en = 1'b0;
  assign sh_if.out_ready = 1'b1; assign l1_if.out_ready = 1'b1; assign l9_if.out_ready = 1'b1;
  assign v_in_ready[0] = sh_if.in_ready;   assign v_out_valid[0] = sh_if.out_valid;
  assign v_in_ready[1] = l1_if.in_ready;   assign v_out_valid[1] = l1_if.out_valid;
  assign v_in_ready[2] = l9_if.in_ready;   assign v_out_valid[2] = l9_if.out_valid;
  assign v_out_px[0] = sh_if.out_px;       assign v_out_sat[0] = sh_if.out_sat;
  assign v_out_px[1] = l1_if.out_px;       assign v_out_sat[1] = l1_if.out_sat;
  assign v_out_px[2] = l9_if.out_px;       assign v_out_sat[2] = l9_if.out_sat;

  // ---------------- checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- scoreboard: {sat, px}
  logic [OW:0] exp_q[$];
  logic [OW:0] drv_exp;
  int          hs_cyc[$];
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_if.in_valid && m_if.in_ready) begin
        exp_q.push_back(drv_exp);
        hs_cyc.push_back(cyc);
      end
      if (m_if.out_valid && m_if.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_underflow: got %0h with no result expected", {m_if.out_sat, m_if.out_px});
        end else begin
          check("out_result", 32'({m_if.out_sat, m_if.out_px}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- model and helpers
  function automatic logic [ELEMS*PW-1:0] fill(input logic [7:0] v);
    logic [ELEMS*PW-1:0] r;
    for (int i = 0; i < ELEMS; i++) r[i*PW +: PW] = v;
    return r;
  endfunction

  function automatic logic [OW:0] model(input logic [ELEMS*PW-1:0] w, input logic [ELEMS*WW-1:0] k,
                                        input logic signed [BW-1:0] b, input logic relu);
    longint s;
    logic [63:0] raw;
    s = b;
    for (int i = 0; i < ELEMS; i++)
      s += longint'($signed(w[i*PW +: PW])) * longint'($signed(k[i*WW +: WW]));
    raw = 64'(s);
    s = longint'($signed(raw[31:0]));
    if (relu && s < 0) s = 0;
    if (s > 32767) return {1'b1, 16'h7fff};
    if (s < -32768) return {1'b1, 16'h8000};
    raw = 64'(s);
    return {1'b0, raw[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [ELEMS*PW-1:0] w, input logic [ELEMS*WW-1:0] k,
                       input logic [BW-1:0] b, input logic relu, input logic [OW:0] exp);
    int n;
    n = 0;
    while (!m_if.in_ready && n < 200) begin tick(); n++; end
    check("in_ready_wait", 32'(m_if.in_ready), 32'd1);
    m_if.window = w; m_if.weights = k; m_if.bias = b; m_if.relu_en = relu;
    drv_exp = exp;
    m_if.in_valid = 1'b1;
    tick();
    m_if.in_valid = 1'b0;
    m_if.window = '1; m_if.weights = '1; m_if.bias = '1; m_if.relu_en = ~relu;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!m_if.out_valid && lat < 100) begin tick(); lat++; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_variant(input int sel, input string tag, input logic [BW-1:0] b,
                             input int exp_lat, input logic [OW:0] exp);
    int lat;
    lat = 0;
    v_win = fill(8'd1); v_wts = fill(8'd1); v_bias = b;
    check({tag, "_in_ready"}, 32'(v_in_ready[sel]), 32'd1);
    v_valid[sel] = 1'b1;
    tick();
    v_valid[sel] = 1'b0;
    while (!v_out_valid[sel] && lat < 100) begin tick(); lat++; end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, 32'({v_out_sat[sel], v_out_px[sel]}), 32'(exp));
    tick();
  endtask

  // ---------------- main sequence
  initial begin
    int lat;
    logic [ELEMS*PW-1:0] rw;
    logic [ELEMS*WW-1:0] rk;
    logic [BW-1:0]       rb;
    logic                rr;

    rst = 1'b1;
    m_if.in_valid = 1'b0; m_if.out_ready = 1'b1;
    m_if.window = '0; m_if.weights = '0; m_if.bias = '0; m_if.relu_en = 1'b0;
    drv_exp = '0;
    for (int i = 0; i < 3; i++) v_valid[i] = 1'b0;
    v_win = '0; v_wts = '0; v_bias = '0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_out_valid", 32'(m_if.out_valid), 32'd0);
    check("rst_out_px", 32'(m_if.out_px), 32'd0);
    check("rst_out_sat", 32'(m_if.out_sat), 32'd0);
    check("rst_in_ready", 32'(m_if.in_ready), 32'd1);

    // ones * ones + 5 with 9-edge latency
    issue(fill(8'd1), fill(8'd1), 16'd5, 1'b0, {1'b0, 16'd32});
    wait_out(lat);
    check("latency_default", 32'(lat), 32'd9);
    drain();

    // positive and negative saturation
    issue(fill(8'h80), fill(8'h80), 16'd0, 1'b0, {1'b1, 16'h7fff});
    issue(fill(8'h80), fill(8'h7f), 16'd0, 1'b0, {1'b1, 16'h8000});
    // ReLU off / on for a small negative sum
    issue(fill(8'd1), fill(8'hff), 16'd0, 1'b0, {1'b0, 16'hffe5});
    issue(fill(8'd1), fill(8'hff), 16'd0, 1'b1, {1'b0, 16'h0000});
    // ReLU applied before saturation: clipped to 0 without flag
    issue(fill(8'h80), fill(8'h7f), 16'd0, 1'b1, {1'b0, 16'h0000});
    drain();

    // back-to-back throughput with in_valid held high
    m_if.window = fill(8'd1); m_if.weights = fill(8'd1); m_if.bias = 16'd5; m_if.relu_en = 1'b0;
    drv_exp = {1'b0, 16'd32};
    hs_cyc.delete();
    m_if.in_valid = 1'b1;
    lat = 0;
    while (hs_cyc.size() < 3 && lat < 100) begin tick(); lat++; end
    m_if.in_valid = 1'b0;
    check("hs_count", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() >= 3) begin
      check("throughput_1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd11);
      check("throughput_2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd11);
    end
    drain();

    // output stall: hold result, ignore new operands
    m_if.out_ready = 1'b0;
    issue(fill(8'd2), fill(8'd3), 16'hfff0, 1'b0, {1'b0, 16'd146});
    wait_out(lat);
    check("stall_latency", 32'(lat), 32'd9);
    for (int c = 0; c < 5; c++) begin
      m_if.in_valid = 1'b1; m_if.window = fill(8'd7); m_if.bias = 16'd1;
      drv_exp = {1'b0, 16'd190};
      tick();
      check("stall_px", 32'(m_if.out_px), 32'd146);
      check("stall_valid", 32'(m_if.out_valid), 32'd1);
      check("stall_in_ready", 32'(m_if.in_ready), 32'd0);
    end
    m_if.in_valid = 1'b0;
    m_if.out_ready = 1'b1;
    tick();
    check("stall_consumed", 32'(m_if.out_valid), 32'd0);
    check("stall_sb_empty", 32'(exp_q.size()), 32'd0);

    // reset at beat 4 aborts the operation
    issue(fill(8'd1), fill(8'd1), 16'd5, 1'b0, {1'b0, 16'd32});
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("abort_out_valid", 32'(m_if.out_valid), 32'd0);
    check("abort_in_ready", 32'(m_if.in_ready), 32'd1);
    repeat (15) tick();
    check("abort_no_output", 32'(m_if.out_valid), 32'd0);
    issue(fill(8'd2), fill(8'd2), 16'd4, 1'b0, {1'b0, 16'd112});
    wait_out(lat);
    check("post_abort_latency", 32'(lat), 32'd9);
    drain();

    // random operands against the model
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < ELEMS; i++) begin
        rw[i*PW +: PW] = 8'($urandom_range(0, 255));
        rk[i*WW +: WW] = 8'($urandom_range(0, 255));
      end
      rb = 16'($urandom_range(0, 65535));
      rr = 1'($urandom_range(0, 1));
      issue(rw, rk, rb, rr, model(rw, rk, rb, rr));
    end
    drain();

    // parameter variants
    run_variant(0, "shift2_b1", 16'd1, 9, {1'b0, 16'd7});
    run_variant(0, "shift2_b2", 16'd2, 9, {1'b0, 16'd7});
    run_variant(0, "shift2_b3", 16'd3, 9, {1'b0, 16'd8});
    run_variant(1, "lanes1", 16'd5, 27, {1'b0, 16'd32});
    run_variant(2, "lanes9", 16'd5, 3, {1'b0, 16'd32});

    repeat (3) tick();
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/conv2d_mac_array.md
CONV2D_MAC_ARRAY -- requirements
Module: conv2d_mac_array

Interface
REQ-001 Parameters SHALL be: PIXEL_W=8 (signed pixel width); WEIGHT_W=8 (signed weight width); BIAS_W=16 (signed bias width); ACC_W=32 (accumulator width); OUT_W=16 (signed result width); CHANNELS=3 (input channels); WINDOW_ELEMS=9 (kernel taps per channel); LANES=3 (multiplies per cycle); SHIFT=0 (output right-shift).
REQ-002 Derived constants SHALL be: ELEMS=CHANNELS*WINDOW_ELEMS and BEATS=ELEMS/LANES; elaboration SHALL fail if ELEMS%LANES!=0 or if LANES<1.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  operand set offered.
REQ-006 in_ready  out  1  block accepts operands.
REQ-007 window  in  ELEMS*PIXEL_W  signed pixels, element i at bits [i*PIXEL_W +: PIXEL_W], i = ch*WINDOW_ELEMS + tap.
REQ-008 weights  in  ELEMS*WEIGHT_W  signed weights, same indexing as window.
REQ-009 bias  in  BIAS_W  signed bias.
REQ-010 relu_en  in  1  clamp negative results to 0.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 out_px  out  OUT_W  signed result.
REQ-014 out_sat  out  1  result was saturated.

Function
REQ-015 The FSM SHALL have states IDLE, MAC and OUT; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in OUT.
REQ-016 An input handshake (in_valid&&in_ready at an edge) SHALL latch window, weights and relu_en, load acc with bias sign-extended to ACC_W, clear the beat counter and enter MAC.
REQ-017 Each MAC-state edge SHALL add LANES sign-extended products window[b*LANES+l]*weights[b*LANES+l], l=0..LANES-1, to acc, where b is the beat counter; wrap-around in ACC_W is permitted and not flagged.
REQ-018 On the edge completing beat BEATS-1, the FSM SHALL enter OUT and register out_px and out_sat from the final acc; latency from the handshake edge to out_valid=1 SHALL be exactly BEATS edges.
REQ-019 Post-processing SHALL proceed in this order: if SHIFT>0, add 2^(SHIFT-1) and shift right arithmetically by SHIFT; if relu_en is latched, clamp negative values to 0; then saturate to the signed OUT_W range, with out_sat=1 when clipping occurred.
REQ-020 In OUT, out_px and out_sat SHALL hold stable while out_ready=0; on out_valid&&out_ready the FSM SHALL return to IDLE; throughput SHALL be one result per BEATS+2 cycles with out_ready tied high.
REQ-021 in_valid SHALL be ignored outside IDLE; input ports SHALL NOT affect an operation in progress after the handshake edge.
REQ-022 out_ready SHALL be ignored outside OUT.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, clear acc and the beat counter, and set out_valid=0, out_px=0, out_sat=0; in_ready SHALL be 1 in the cycle after reset.
REQ-024 Reset during MAC or OUT SHALL abort the operation, and no result SHALL be emitted; rst SHALL take priority over any simultaneous handshake.

Verification
REQ-025 Defaults, all pixels=1, all weights=1, bias=5 -> out_valid exactly 9 edges after handshake, out_px=32, out_sat=0.
REQ-026 All pixels=-128, all weights=-128, bias=0 -> acc=442368, out_px=32767, out_sat=1.
REQ-027 Pixels=1, weights=-1, bias=0: relu_en=0 -> out_px=-27; relu_en=1 -> out_px=0, out_sat=0.
REQ-028 SHIFT=2, pixels=1, weights=1, bias=1 (acc=28) -> out_px=7; bias=2 (acc=29) -> out_px=7; bias=3 (acc=30) -> out_px=8.
REQ-029 out_ready held 0 for 5 cycles in OUT -> out_px stable, in_ready=0 and new in_valid ignored; result consumed on the first out_ready=1 cycle.
REQ-030 rst pulsed at beat 4 -> out_valid=0 and in_ready=1 the next cycle; a following operation gives a correct result; repeat REQ-025 with LANES=1 (27-edge latency) and LANES=9 (3-edge latency).
